// File: rtl/mem_arbiter.sv
// Arbitrates the memory controller port between ICache fetches, LSB loads/stores and,
// when PREFETCH_EN is defined, a prefetcher. Grant lasts one transaction; response goes to the owner.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int AGE_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             roll,
    input  logic             IC_flag,
    input  logic [31:0]      IC_addr,
    output logic             IC_commit,
    output logic [31:0]      IC_data,
    input  logic             LSB_flag,
    input  logic             LSB_type,
    input  logic [31:0]      LSB_addr,
    input  logic [2:0]       LSB_len,
    input  logic [31:0]      LSB_data,
    output logic             LSB_commit,
    output logic [31:0]      LSB_val,
`ifdef PREFETCH_EN
    input  logic             PF_flag,
    input  logic [31:0]      PF_addr,
    output logic             PF_commit,
    output logic [31:0]      PF_data,
`endif
    output logic             MC_flag,
    output logic             MC_type,
    output logic [31:0]      MC_addr,
    output logic [2:0]       MC_len,
    output logic [31:0]      MC_data,
    input  logic             MC_commit,
    input  logic [31:0]      MC_val,
    output logic             dbg_state,
    output logic [AGE_W-1:0] dbg_age
);

    // Handshake: a requester raises *_flag with stable fields and holds it until its
    // one-cycle *_commit; the controller sees MC_flag high with stable MC_* fields for the
    // whole transaction and ends it with a one-cycle MC_commit, which drops MC_flag at once.
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
`ifdef PREFETCH_EN
    typedef enum logic [1:0] {OWN_NONE, OWN_IC, OWN_LSB, OWN_PF} owner_t;
`else
    typedef enum logic [1:0] {OWN_NONE, OWN_IC, OWN_LSB} owner_t;
`endif

    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

    state_t           state, state_n;
    owner_t           owner, pick;
    logic [AGE_W-1:0] age;
    logic             grant, finish, store_keep;

    // A store already handed to the controller cannot be recalled, so roll leaves it running.
    assign store_keep = (owner == OWN_LSB) && MC_type;
    assign MC_flag    = (state == BUSY) && !MC_commit;
    assign dbg_state  = state;
    assign dbg_age    = age;

    always_comb begin
        state_n = state;
        pick    = OWN_NONE;
        grant   = 1'b0;
        finish  = 1'b0;
        if (rdy) begin
            case (state)
                IDLE: begin
                    if (!roll) begin
                        if (IC_flag && age == AGE_MAX) pick = OWN_IC;
                        else if (LSB_flag)             pick = OWN_LSB;
                        else if (IC_flag)              pick = OWN_IC;
`ifdef PREFETCH_EN
                        else if (PF_flag)              pick = OWN_PF;
`endif
                        if (pick != OWN_NONE) begin
                            grant   = 1'b1;
                            state_n = BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (roll && !store_keep) begin
                        state_n = IDLE;
                    end else if (MC_commit) begin
                        finish  = 1'b1;
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= OWN_NONE;
            age        <= '0;
            IC_commit  <= 1'b0;
            IC_data    <= '0;
            LSB_commit <= 1'b0;
            LSB_val    <= '0;
`ifdef PREFETCH_EN
            PF_commit  <= 1'b0;
            PF_data    <= '0;
`endif
            MC_type    <= 1'b0;
            MC_addr    <= '0;
            MC_len     <= '0;
            MC_data    <= '0;
        end else begin
            state      <= state_n;
            IC_commit  <= 1'b0;
            LSB_commit <= 1'b0;
`ifdef PREFETCH_EN
            PF_commit  <= 1'b0;
`endif
            if (grant) begin
                owner <= pick;
                case (pick)
                    OWN_LSB: begin
                        MC_type <= LSB_type;
                        MC_addr <= LSB_addr;
                        MC_len  <= LSB_len;
                        MC_data <= LSB_data;
                        if (!IC_flag)           age <= '0;
                        else if (age != AGE_MAX) age <= age + AGE_W'(1);
                    end
`ifdef PREFETCH_EN
                    OWN_PF: begin
                        MC_type <= 1'b0;
                        MC_addr <= PF_addr;
                        MC_len  <= 3'd4;
                        MC_data <= '0;
                        age     <= '0;
                    end
`endif
                    default: begin
                        MC_type <= 1'b0;
                        MC_addr <= IC_addr;
                        MC_len  <= 3'd4;
                        MC_data <= '0;
                        age     <= '0;
                    end
                endcase
            end else if (state == BUSY && state_n == IDLE) begin
                owner <= OWN_NONE;
            end
            if (finish) begin
                case (owner)
                    OWN_IC: begin
                        IC_commit <= 1'b1;
                        IC_data   <= MC_val;
                    end
                    OWN_LSB: begin
                        LSB_commit <= 1'b1;
                        LSB_val    <= MC_val;
                    end
`ifdef PREFETCH_EN
                    OWN_PF: begin
                        PF_commit <= 1'b1;
                        PF_data   <= MC_val;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios, then randomized requesters and controller
// checked against a transaction-level arbitration model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst, rdy, roll;
    logic        IC_flag, IC_commit;
    logic [31:0] IC_addr, IC_data;
    logic        LSB_flag, LSB_type, LSB_commit;
    logic [31:0] LSB_addr, LSB_data, LSB_val;
    logic [2:0]  LSB_len;
`ifdef PREFETCH_EN
    logic        PF_flag, PF_commit;
    logic [31:0] PF_addr, PF_data;
`endif
    logic        MC_flag, MC_type, MC_commit;
    logic [31:0] MC_addr, MC_data, MC_val;
    logic [2:0]  MC_len;
    logic        dbg_state;
    logic [3:0]  dbg_age;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    mem_arbiter #(.STARVE_LIMIT(8), .AGE_W(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .roll(roll),
        .IC_flag(IC_flag), .IC_addr(IC_addr), .IC_commit(IC_commit), .IC_data(IC_data),
        .LSB_flag(LSB_flag), .LSB_type(LSB_type), .LSB_addr(LSB_addr), .LSB_len(LSB_len),
        .LSB_data(LSB_data), .LSB_commit(LSB_commit), .LSB_val(LSB_val),
`ifdef PREFETCH_EN
        .PF_flag(PF_flag), .PF_addr(PF_addr), .PF_commit(PF_commit), .PF_data(PF_data),
`endif
        .MC_flag(MC_flag), .MC_type(MC_type), .MC_addr(MC_addr), .MC_len(MC_len),
        .MC_data(MC_data), .MC_commit(MC_commit), .MC_val(MC_val),
        .dbg_state(dbg_state), .dbg_age(dbg_age)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(negedge clk);
    endtask

    task automatic respond(input logic [31:0] v);
        MC_commit = 1'b1;
        MC_val    = v;
        #1 check("mc_flag_drops_on_commit", 32'(MC_flag), 0);
        @(negedge clk);
        MC_commit = 1'b0;
    endtask

    // randomized-phase model state
    int          streak;
    bit          m_busy;
    int          m_owner;
    int          dly;
    logic [31:0] e_addr, e_data;
    logic [2:0]  e_len;
    logic        e_type;

    initial begin
        rst = 1'b0; rdy = 1'b1; roll = 1'b0;
        IC_flag = 1'b0; IC_addr = '0;
        LSB_flag = 1'b0; LSB_type = 1'b0; LSB_addr = '0; LSB_len = '0; LSB_data = '0;
`ifdef PREFETCH_EN
        PF_flag = 1'b0; PF_addr = '0;
`endif
        MC_commit = 1'b0; MC_val = '0;
        repeat (2) step();
        check("rst_mc_flag",    32'(MC_flag),    0);
        check("rst_ic_commit",  32'(IC_commit),  0);
        check("rst_lsb_commit", 32'(LSB_commit), 0);
        check("rst_ic_data",    IC_data,         0);
        check("rst_lsb_val",    LSB_val,         0);
        check("rst_mc_addr",    MC_addr,         0);
        check("rst_mc_len",     32'(MC_len),     0);
        check("rst_state",      32'(dbg_state),  0);
        check("rst_age",        32'(dbg_age),    0);
        rst = 1'b1;
        step();

        // fetch
        IC_flag = 1'b1; IC_addr = 32'h1000;
        step();
        check("fetch_mc_flag", 32'(MC_flag), 1);
        check("fetch_mc_addr", MC_addr, 32'h1000);
        check("fetch_mc_len",  32'(MC_len), 4);
        check("fetch_mc_type", 32'(MC_type), 0);
        respond(32'h00C0FFEE);
        check("fetch_ic_commit", 32'(IC_commit), 1);
        check("fetch_ic_data",   IC_data, 32'h00C0FFEE);
        IC_flag = 1'b0;
        step();
        check("fetch_commit_pulse", 32'(IC_commit), 0);

        // contention: LSB wins, IC after one idle cycle
        IC_flag = 1'b1; IC_addr = 32'h1100;
        LSB_flag = 1'b1; LSB_type = 1'b0; LSB_addr = 32'h2000; LSB_len = 3'd2;
        step();
        check("cont_lsb_addr", MC_addr, 32'h2000);
        check("cont_lsb_len",  32'(MC_len), 2);
        respond(32'h1234);
        check("cont_lsb_commit", 32'(LSB_commit), 1);
        check("cont_lsb_val",    LSB_val, 32'h1234);
        check("cont_idle_gap",   32'(MC_flag), 0);
        LSB_flag = 1'b0;
        step();
        check("cont_ic_flag", 32'(MC_flag), 1);
        check("cont_ic_addr", MC_addr, 32'h1100);
        respond(32'hABCD0001);
        check("cont_ic_commit", 32'(IC_commit), 1);
        IC_flag = 1'b0;
        step();

        // starvation
        IC_flag = 1'b1; IC_addr = 32'h4000;
        LSB_flag = 1'b1; LSB_type = 1'b0; LSB_len = 3'd4;
        for (int i = 0; i < 8; i++) begin
            LSB_addr = 32'h5000 + 32'(i * 4);
            step();
            check("starve_lsb_addr", MC_addr, 32'h5000 + 32'(i * 4));
            respond(32'(i));
            check("starve_lsb_commit", 32'(LSB_commit), 1);
        end
        check("starve_age_full", 32'(dbg_age), 8);
        step();
        check("starve_ic_wins", MC_addr, 32'h4000);
        check("starve_age_clr", 32'(dbg_age), 0);
        LSB_flag = 1'b0;
        respond(32'hA5A5A5A5);
        check("starve_ic_data", IC_data, 32'hA5A5A5A5);
        IC_flag = 1'b0;
        step();

        // roll during fetch, with a colliding MC_commit discarded
        IC_flag = 1'b1; IC_addr = 32'h6000;
        step();
        check("rollf_busy", 32'(MC_flag), 1);
        roll = 1'b1; MC_commit = 1'b1; MC_val = 32'hDEAD0000;
        step();
        roll = 1'b0; MC_commit = 1'b0; IC_flag = 1'b0;
        check("rollf_mc_flag",   32'(MC_flag),   0);
        check("rollf_no_commit", 32'(IC_commit), 0);
        check("rollf_state",     32'(dbg_state), 0);
        step();
        check("rollf_no_regrant", 32'(MC_flag), 0);

        // roll during store
        LSB_flag = 1'b1; LSB_type = 1'b1; LSB_addr = 32'h30000; LSB_len = 3'd4;
        LSB_data = 32'hDEADBEEF;
        step();
        check("rolls_type", 32'(MC_type), 1);
        check("rolls_data", MC_data, 32'hDEADBEEF);
        roll = 1'b1;
        step();
        roll = 1'b0;
        check("rolls_state",   32'(dbg_state), 1);
        check("rolls_mc_flag", 32'(MC_flag), 1);
        check("rolls_mc_addr", MC_addr, 32'h30000);
        respond(32'h0);
        check("rolls_commit", 32'(LSB_commit), 1);
        LSB_flag = 1'b0;
        step();

        // rdy low for three cycles mid-transaction
        IC_flag = 1'b1; IC_addr = 32'h7000;
        step();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin MC_commit = 1'b1; MC_val = 32'h00000BAD; end
            step();
            MC_commit = 1'b0;
            check("rdy_hold_addr", MC_addr, 32'h7000);
            check("rdy_no_commit", 32'(IC_commit), 0);
            check("rdy_hold_state", 32'(dbg_state), 1);
        end
        rdy = 1'b1;
        respond(32'h11223344);
        check("rdy_resume_commit", 32'(IC_commit), 1);
        check("rdy_resume_data",   IC_data, 32'h11223344);
        IC_flag = 1'b0;
        step();

`ifdef PREFETCH_EN
        PF_flag = 1'b1; PF_addr = 32'h8000; IC_flag = 1'b1; IC_addr = 32'h9000;
        step();
        check("pf_ic_first", MC_addr, 32'h9000);
        respond(32'h66);
        check("pf_ic_commit", 32'(IC_commit), 1);
        IC_flag = 1'b0;
        step();
        check("pf_addr", MC_addr, 32'h8000);
        respond(32'h77);
        check("pf_commit", 32'(PF_commit), 1);
        check("pf_data",   PF_data, 32'h77);
        PF_flag = 1'b0;
        step();
`endif

        // reset mid-transaction
        IC_flag = 1'b1; IC_addr = 32'h7100;
        step();
        check("rstb_busy", 32'(MC_flag), 1);
        rst = 1'b0; IC_flag = 1'b0;
        step();
        check("rstb_mc_flag", 32'(MC_flag), 0);
        check("rstb_state",   32'(dbg_state), 0);
        check("rstb_mc_addr", MC_addr, 0);
        rst = 1'b1;

        // randomized traffic against the arbitration model
        streak = 0; m_busy = 1'b0; m_owner = 0; dly = 0;
        e_addr = '0; e_data = '0; e_len = '0; e_type = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit granted, exp_ic, exp_lsb;
            step();
            granted = 1'b0; exp_ic = 1'b0; exp_lsb = 1'b0;
            if (m_busy) begin
                if (MC_commit) begin
                    exp_ic  = (m_owner == 1);
                    exp_lsb = (m_owner == 2);
                    if (exp_ic || !e_type) exp_q.push_back(MC_val);
                    m_busy = 1'b0;
                end
            end else if (IC_flag || LSB_flag) begin
                if (IC_flag && streak == 8) m_owner = 1;
                else if (LSB_flag)          m_owner = 2;
                else                        m_owner = 1;
                if (m_owner == 2) begin
                    streak = IC_flag ? ((streak == 8) ? 8 : streak + 1) : 0;
                    e_addr = LSB_addr; e_len = LSB_len; e_type = LSB_type; e_data = LSB_data;
                end else begin
                    streak = 0;
                    e_addr = IC_addr; e_len = 3'd4; e_type = 1'b0; e_data = '0;
                end
                m_busy = 1'b1; granted = 1'b1;
                dly = $urandom_range(0, 3);
            end
            check("rnd_mc_flag",    32'(MC_flag),    32'(m_busy));
            check("rnd_ic_commit",  32'(IC_commit),  32'(exp_ic));
            check("rnd_lsb_commit", 32'(LSB_commit), 32'(exp_lsb));
            check("rnd_age",        32'(dbg_age),    32'(streak));
            if (exp_ic && exp_q.size() > 0)  check("rnd_ic_data", IC_data, exp_q.pop_front());
            if (exp_lsb && exp_q.size() > 0) check("rnd_lsb_val", LSB_val, exp_q.pop_front());
            if (granted) begin
                check("rnd_mc_addr", MC_addr,       e_addr);
                check("rnd_mc_len",  32'(MC_len),   32'(e_len));
                check("rnd_mc_type", 32'(MC_type),  32'(e_type));
                if (e_type) check("rnd_mc_data", MC_data, e_data);
            end
            // controller responder
            MC_commit = 1'b0;
            if (m_busy) begin
                if (dly == 0) begin
                    MC_commit = 1'b1;
                    MC_val    = $urandom;
                end else begin
                    dly--;
                end
            end
            // requesters
            if (IC_commit) IC_flag = 1'b0;
            if (!IC_flag && $urandom_range(0, 3) == 0) begin
                IC_flag = 1'b1;
                IC_addr = {$urandom_range(0, 32'h3FFF), 2'b00};
            end
            if (LSB_commit) LSB_flag = 1'b0;
            if (!LSB_flag && $urandom_range(0, 3) != 0) begin
                int k;
                k        = $urandom_range(0, 2);
                LSB_flag = 1'b1;
                LSB_type = 1'($urandom_range(0, 1));
                LSB_addr = $urandom;
                LSB_len  = (k == 0) ? 3'd1 : (k == 1) ? 3'd2 : 3'd4;
                LSB_data = $urandom;
            end
        end

        // report
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
